// File: rtl/uart_txn_pkg.sv
// Shared types and helpers for the UART transaction engine.
package uart_txn_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32'd8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_WAIT_RX = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   // Saturate a requested byte count to the buffer depth.
   function automatic int unsigned clamp_len(input int unsigned req_len,
                                             input int unsigned depth);
      if (req_len > depth) begin
         return depth;
      end else begin
         return req_len;
      end
   endfunction

endpackage

// File: rtl/uart_txn_rx_collect.sv
// Response collector: stores incoming bytes in order, counts them and
// aborts the wait after TIMEOUT_P consecutive idle cycles.
module uart_txn_rx_collect
   import uart_txn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH_P = DATA_WIDTH_DEF,
   parameter int unsigned RX_DEPTH_P   = 32'd8,
   parameter int unsigned TIMEOUT_P    = 32'd65535
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic                                 en,
   input  logic [$clog2(RX_DEPTH_P+1)-1:0]      rx_len,
   input  logic                                 byte_valid,
   input  logic [DATA_WIDTH_P-1:0]              byte_data,
   output logic                                 done,
   output logic                                 expire,
   output logic                                 timeout,
   output logic [RX_DEPTH_P*DATA_WIDTH_P-1:0]   data,
   output logic [$clog2(RX_DEPTH_P+1)-1:0]      len
);

   localparam int unsigned LEN_W = $clog2(RX_DEPTH_P + 32'd1);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_P + 32'd1);
   localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_P - 32'd1);

   logic [LEN_W-1:0]                 idx_r;
   logic [LEN_W-1:0]                 idx_nxt_s;
   logic [CNT_W-1:0]                 idle_cnt_r;
   logic [RX_DEPTH_P*DATA_WIDTH_P-1:0] data_r;
   logic                             timeout_r;
   logic                             fire_s;

   assign idx_nxt_s = idx_r + LEN_W'(1);
   assign fire_s    = en && byte_valid && (idx_r < rx_len);
   // A byte on the expiry cycle wins, so expiry requires an idle cycle.
   assign expire    = en && !byte_valid && (idle_cnt_r == IDLE_LIMIT);
   assign done      = fire_s && (idx_nxt_s == rx_len);

   assign timeout = timeout_r;
   assign data    = data_r;
   assign len     = idx_r;

   // Byte buffer, fill index, idle counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r      <= {LEN_W{1'b0}};
         idle_cnt_r <= {CNT_W{1'b0}};
         data_r     <= {(RX_DEPTH_P*DATA_WIDTH_P){1'b0}};
         timeout_r  <= 1'b0;
      end else if (start) begin
         idx_r      <= {LEN_W{1'b0}};
         idle_cnt_r <= {CNT_W{1'b0}};
         data_r     <= {(RX_DEPTH_P*DATA_WIDTH_P){1'b0}};
         timeout_r  <= 1'b0;
      end else if (fire_s) begin
         data_r[32'(idx_r)*DATA_WIDTH_P +: DATA_WIDTH_P] <= byte_data;
         idx_r      <= idx_nxt_s;
         idle_cnt_r <= {CNT_W{1'b0}};
      end else if (en) begin
         if (idle_cnt_r == IDLE_LIMIT) begin
            timeout_r <= 1'b1;
         end else begin
            idle_cnt_r <= idle_cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_txn_engine.sv
// Host-side UART transaction engine: sends one request packet over an
// AXI-stream UART, then gathers the response with an inactivity timeout.
module uart_txn_engine
   import uart_txn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH_P = DATA_WIDTH_DEF,
   parameter int unsigned TX_DEPTH_P   = 32'd8,
   parameter int unsigned RX_DEPTH_P   = 32'd8,
   parameter int unsigned TIMEOUT_P    = 32'd65535
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 req_valid_i,
   output logic                                 req_ready_o,
   input  logic [TX_DEPTH_P*DATA_WIDTH_P-1:0]   req_data_i,
   input  logic [$clog2(TX_DEPTH_P+1)-1:0]      req_tx_len_i,
   input  logic [$clog2(RX_DEPTH_P+1)-1:0]      req_rx_len_i,
   output logic [DATA_WIDTH_P-1:0]              uart_tdata_o,
   output logic                                 uart_tvalid_o,
   input  logic                                 uart_tready_i,
   input  logic [DATA_WIDTH_P-1:0]              uart_rdata_i,
   input  logic                                 uart_rvalid_i,
   output logic                                 uart_rready_o,
   output logic                                 rsp_valid_o,
   input  logic                                 rsp_ready_i,
   output logic [RX_DEPTH_P*DATA_WIDTH_P-1:0]   rsp_data_o,
   output logic [$clog2(RX_DEPTH_P+1)-1:0]      rsp_len_o,
   output logic                                 rsp_timeout_o,
   output logic                                 drop_o,
   output logic                                 busy_o
);

   localparam int unsigned TXL_W = $clog2(TX_DEPTH_P + 32'd1);
   localparam int unsigned RXL_W = $clog2(RX_DEPTH_P + 32'd1);

   state_e                           state_r;
   state_e                           state_s;
   logic [TX_DEPTH_P*DATA_WIDTH_P-1:0] tx_buf_r;
   logic [TXL_W-1:0]                 tx_len_r;
   logic [TXL_W-1:0]                 tx_idx_r;
   logic [TXL_W-1:0]                 tx_idx_nxt_s;
   logic [TXL_W-1:0]                 tx_len_s;
   logic [RXL_W-1:0]                 rx_len_r;
   logic [RXL_W-1:0]                 rx_len_s;
   logic [DATA_WIDTH_P-1:0]          tdata_r;
   logic                             tvalid_r;
   logic                             req_ready_r;
   logic                             busy_r;
   logic                             rsp_valid_r;
   logic                             drop_r;
   logic                             accept_s;
   logic                             tx_hs_s;
   logic                             tx_last_s;
   logic                             rx_en_s;
   logic                             rx_done_s;
   logic                             rx_expire_s;

   assign tx_len_s     = TXL_W'(clamp_len(32'(req_tx_len_i), TX_DEPTH_P));
   assign rx_len_s     = RXL_W'(clamp_len(32'(req_rx_len_i), RX_DEPTH_P));
   assign accept_s     = req_valid_i && req_ready_r;
   assign tx_hs_s      = (state_r == ST_SEND) && tvalid_r && uart_tready_i;
   assign tx_idx_nxt_s = tx_idx_r + TXL_W'(1);
   assign tx_last_s    = tx_hs_s && (tx_idx_nxt_s == tx_len_r);
   assign rx_en_s      = (state_r == ST_WAIT_RX);

   assign req_ready_o   = req_ready_r;
   assign busy_o        = busy_r;
   assign rsp_valid_o   = rsp_valid_r;
   assign drop_o        = drop_r;
   assign uart_tdata_o  = tdata_r;
   assign uart_tvalid_o = tvalid_r;
   // The engine never backpressures the UART receiver; unwanted bytes are
   // flagged through drop_o instead.
   assign uart_rready_o = 1'b1;

   // Next-state decode for the request/response sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (tx_len_s != {TXL_W{1'b0}}) begin
                  state_s = ST_SEND;
               end else if (rx_len_s != {RXL_W{1'b0}}) begin
                  state_s = ST_WAIT_RX;
               end else begin
                  state_s = ST_DONE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (tx_last_s) begin
               if (rx_len_r != {RXL_W{1'b0}}) begin
                  state_s = ST_WAIT_RX;
               end else begin
                  state_s = ST_DONE;
               end
            end else begin
               state_s = ST_SEND;
            end
         end
         ST_WAIT_RX: begin
            if (rx_done_s || rx_expire_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_WAIT_RX;
            end
         end
         ST_DONE: begin
            if (rsp_ready_i) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register plus registered status flags decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         req_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         rsp_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         req_ready_r <= (state_s == ST_IDLE);
         busy_r      <= (state_s != ST_IDLE);
         rsp_valid_r <= (state_s == ST_DONE);
      end
   end

   // Request capture and transmit byte sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_buf_r <= {(TX_DEPTH_P*DATA_WIDTH_P){1'b0}};
         tx_len_r <= {TXL_W{1'b0}};
         rx_len_r <= {RXL_W{1'b0}};
         tx_idx_r <= {TXL_W{1'b0}};
         tdata_r  <= {DATA_WIDTH_P{1'b0}};
         tvalid_r <= 1'b0;
      end else if (accept_s) begin
         tx_buf_r <= req_data_i;
         tx_len_r <= tx_len_s;
         rx_len_r <= rx_len_s;
         tx_idx_r <= {TXL_W{1'b0}};
         if (tx_len_s != {TXL_W{1'b0}}) begin
            tdata_r  <= req_data_i[DATA_WIDTH_P-1:0];
            tvalid_r <= 1'b1;
         end else begin
            tdata_r  <= {DATA_WIDTH_P{1'b0}};
            tvalid_r <= 1'b0;
         end
      end else if (tx_hs_s) begin
         tx_idx_r <= tx_idx_nxt_s;
         if (tx_last_s) begin
            tdata_r  <= {DATA_WIDTH_P{1'b0}};
            tvalid_r <= 1'b0;
         end else begin
            tdata_r  <= tx_buf_r[32'(tx_idx_nxt_s)*DATA_WIDTH_P +: DATA_WIDTH_P];
            tvalid_r <= 1'b1;
         end
      end
   end

   // Sticky flag for bytes arriving while no response is being collected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_r <= 1'b0;
      end else if (accept_s) begin
         drop_r <= uart_rvalid_i;
      end else if (uart_rvalid_i && (state_r != ST_WAIT_RX)) begin
         drop_r <= 1'b1;
      end
   end

   uart_txn_rx_collect #(
      .DATA_WIDTH_P (DATA_WIDTH_P),
      .RX_DEPTH_P   (RX_DEPTH_P),
      .TIMEOUT_P    (TIMEOUT_P)
   ) u_rx_collect (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (accept_s),
      .en         (rx_en_s),
      .rx_len     (rx_len_r),
      .byte_valid (uart_rvalid_i),
      .byte_data  (uart_rdata_i),
      .done       (rx_done_s),
      .expire     (rx_expire_s),
      .timeout    (rsp_timeout_o),
      .data       (rsp_data_o),
      .len        (rsp_len_o)
   );

endmodule
